// File: rtl/mul_issue.sv
// rtl/mul_issue.sv - operand queue and issue/collect sequencer for a serial multiplier
// A small FIFO buffers operand pairs; the FSM issues one at a time and holds each result.

module mul_issue_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 68
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module mul_issue #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [3:0]  in_tag,
  output logic        mul_start,
  output logic [31:0] mul_mc,
  output logic [31:0] mul_mp,
  input  logic [63:0] mul_p,
  input  logic        mul_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_prod,
  output logic [3:0]  out_tag,
  output logic        out_timeout,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state, state_next;
  logic          fifo_full, fifo_empty, push, pop;
  logic [67:0]   fifo_rdata;
  logic [31:0]   op_a, op_b;
  logic [3:0]    op_tag;
  logic [TW-1:0] wait_cnt;
  logic          expired;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign pop      = (state == IDLE) && !fifo_empty;
  assign expired  = (wait_cnt == LAST_WAIT);

  mul_issue_fifo #(.DEPTH(DEPTH), .W(68)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_tag, in_a, in_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (mul_done || expired) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // mul_done is only looked at in WAIT; elsewhere it may still be high from the previous op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      op_tag      <= '0;
      wait_cnt    <= '0;
      out_prod    <= '0;
      out_tag     <= '0;
      out_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) {op_tag, op_a, op_b} <= fifo_rdata;
      case (state)
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + TW'(1);
          if (mul_done) begin
            out_prod    <= mul_p;
            out_tag     <= op_tag;
            out_timeout <= 1'b0;
          end else if (expired) begin
            out_prod    <= '0;
            out_tag     <= op_tag;
            out_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_start = (state == ISSUE);
  assign mul_mc    = op_a;
  assign mul_mp    = op_b;
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_mul_issue.sv
// tb/tb_mul_issue.sv - directed bench for mul_issue with a behavioural serial multiplier
// The multiplier raises done 66 cycles after start and holds it until the next start.

module tb_mul_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        mul_start;
  logic [31:0] mul_mc, mul_mp;
  logic [63:0] mul_p;
  logic        mul_done;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;
  logic [3:0]  out_tag;
  logic        out_timeout;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic        never_done;
  int          mcnt;
  logic [31:0] mc_l, mp_l;

  mul_issue #(.DEPTH(2), .TIMEOUT(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .mul_start   (mul_start),
    .mul_mc      (mul_mc),
    .mul_mp      (mul_mp),
    .mul_p       (mul_p),
    .mul_done    (mul_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_prod    (out_prod),
    .out_tag     (out_tag),
    .out_timeout (out_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mul_done <= 1'b0;
      mul_p    <= '0;
      mcnt     <= 0;
    end else if (mul_start) begin
      mul_done <= 1'b0;
      mcnt     <= 66;
      mc_l     <= mul_mc;
      mp_l     <= mul_mp;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !never_done) begin
        mul_done <= 1'b1;
        mul_p    <= 64'(mc_l) * 64'(mp_l);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, " in_ready"}, 64'(in_ready), 64'd1);
    chk({pfx, " mul_start"}, 64'(mul_start), 64'd0);
    chk({pfx, " mul_mc"}, 64'(mul_mc), 64'd0);
    chk({pfx, " mul_mp"}, 64'(mul_mp), 64'd0);
    chk({pfx, " out_valid"}, 64'(out_valid), 64'd0);
    chk({pfx, " out_prod"}, out_prod, 64'd0);
    chk({pfx, " out_tag"}, 64'(out_tag), 64'd0);
    chk({pfx, " out_timeout"}, 64'(out_timeout), 64'd0);
    chk({pfx, " busy"}, 64'(busy), 64'd0);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      tick;
      n++;
    end
    chk({name, " out_valid"}, 64'(out_valid), 64'd1);
  endtask

  // Push one op into an idle, empty block with out_ready=1 and check the whole transaction.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [63:0] exp_prod,
                        input logic exp_to, input int exp_lat);
    int n;
    push(a, b, tag);
    n = 0;
    while (!mul_start && n < 10) begin
      tick;
      n++;
    end
    chk({name, " start_lat"}, 64'(n), 64'd1);
    chk({name, " mul_mc"}, 64'(mul_mc), 64'(a));
    chk({name, " mul_mp"}, 64'(mul_mp), 64'(b));
    tick;
    chk({name, " start_pulse"}, 64'(mul_start), 64'd0);
    n = 1;
    while (!out_valid && n < 300) begin
      tick;
      n++;
    end
    chk({name, " out_lat"}, 64'(n), 64'(exp_lat));
    chk({name, " out_prod"}, out_prod, exp_prod);
    chk({name, " out_tag"}, 64'(out_tag), 64'(tag));
    chk({name, " out_timeout"}, 64'(out_timeout), 64'(exp_to));
    tick;
    chk({name, " consumed"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int   n;
    logic seen_valid, seen_start;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_tag     = '0;
    out_ready  = 1'b1;
    never_done = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    chk_reset("reset");

    run_op("op3x5", 32'd3, 32'd5, 4'd1, 64'd15, 1'b0, 68);
    run_op("opmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 64'hFFFF_FFFE_0000_0001, 1'b0, 68);
    // done and mul_p are still high/stale from the previous op during this ISSUE
    run_op("opzero", 32'd0, 32'h1234, 4'd3, 64'd0, 1'b0, 68);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 32'd2;   in_b = 32'd3;    in_tag = 4'd1;
    chk("b2b ready0", 64'(in_ready), 64'd1);
    tick;
    in_a = 32'd7;   in_b = 32'd9;    in_tag = 4'd2;
    chk("b2b ready1", 64'(in_ready), 64'd1);
    tick;
    in_a = 32'd100; in_b = 32'd1000; in_tag = 4'd3;
    chk("b2b ready2", 64'(in_ready), 64'd1);
    tick;
    in_valid = 1'b0;
    chk("b2b full", 64'(in_ready), 64'd0);
    chk("b2b busy", 64'(busy), 64'd1);
    wait_valid("b2b r1");
    chk("b2b r1 prod", out_prod, 64'd6);
    chk("b2b r1 tag", 64'(out_tag), 64'd1);
    repeat (3) tick;
    chk("b2b hold valid", 64'(out_valid), 64'd1);
    chk("b2b hold prod", out_prod, 64'd6);
    chk("b2b hold tag", 64'(out_tag), 64'd1);
    chk("b2b hold full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    wait_valid("b2b r2");
    chk("b2b r2 prod", out_prod, 64'd63);
    chk("b2b r2 tag", 64'(out_tag), 64'd2);
    chk("b2b r2 ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    wait_valid("b2b r3");
    chk("b2b r3 prod", out_prod, 64'd100000);
    chk("b2b r3 tag", 64'(out_tag), 64'd3);
    out_ready = 1'b1;
    tick;
    chk("b2b idle", 64'(busy), 64'd0);

    never_done = 1'b1;
    run_op("tmo", 32'd4, 32'd4, 4'd5, 64'd0, 1'b1, 101);
    never_done = 1'b0;
    run_op("after_tmo", 32'd6, 32'd7, 4'd6, 64'd42, 1'b0, 68);

    push(32'd11, 32'd13, 4'd7);
    n = 0;
    while (!mul_start && n < 10) begin
      tick;
      n++;
    end
    chk("rstwait start", 64'(mul_start), 64'd1);
    repeat (10) tick;
    push(32'd2, 32'd2, 4'd8);
    chk("rstwait busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick;
    chk_reset("midreset");
    rst = 1'b0;
    seen_valid = 1'b0;
    seen_start = 1'b0;
    repeat (150) begin
      tick;
      if (out_valid) seen_valid = 1'b1;
      if (mul_start) seen_start = 1'b1;
    end
    chk("discard no_valid", 64'(seen_valid), 64'd0);
    chk("discard no_start", 64'(seen_start), 64'd0);
    run_op("post_rst", 32'd9, 32'd9, 4'd9, 64'd81, 1'b0, 68);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_issue.md
MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving operand FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 100, giving max WAIT cycles before abort.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  FIFO can accept.
REQ-007 in_a  in  32  multiplicand.
REQ-008 in_b  in  32  multiplier.
REQ-009 in_tag  in  4  caller ID, returned with result.
REQ-010 mul_start  out  1  start pulse to serial multiplier.
REQ-011 mul_mc  out  32  multiplicand to multiplier.
REQ-012 mul_mp  out  32  multiplier operand to multiplier.
REQ-013 mul_p  in  64  product from multiplier.
REQ-014 mul_done  in  1  multiplier done level (held high until next start).
REQ-015 out_valid  out  1  result available.
REQ-016 out_ready  in  1  consumer accepts result.
REQ-017 out_prod  out  64  product.
REQ-018 out_tag  out  4  tag of result.
REQ-019 out_timeout  out  1  result aborted by timeout.
REQ-020 busy  out  1  FSM not IDLE or FIFO non-empty.

Function
REQ-021 Input push SHALL occur when in_valid && in_ready; in_ready SHALL equal !full, independent of same-cycle pop.
REQ-022 FIFO SHALL be first-in-first-out, {tag,a,b} per entry, pointers wrapping modulo DEPTH, full/empty via occupancy count 0..DEPTH.
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-024 IDLE && FIFO non-empty SHALL pop head into operand register and go to ISSUE next cycle; else stay IDLE.
REQ-025 ISSUE SHALL assert mul_start for exactly one cycle, clear wait counter, go to WAIT.
REQ-026 mul_mc/mul_mp SHALL drive operand register, stable from ISSUE until next pop.
REQ-027 mul_done SHALL be ignored in IDLE, ISSUE and HOLD (stale done from prior operation).
REQ-028 WAIT: counter increments each cycle; mul_done=1 SHALL capture mul_p into out_prod, out_timeout=0, go to HOLD.
REQ-029 WAIT: counter reaching TIMEOUT with mul_done=0 SHALL set out_prod=0, out_timeout=1, go to HOLD; done and timeout in same cycle SHALL count as done.
REQ-030 HOLD SHALL assert out_valid with out_prod/out_tag/out_timeout stable until out_ready; out_valid && out_ready SHALL go to IDLE.
REQ-031 Latency: mul_start SHALL rise 2 cycles after push into empty FIFO while IDLE; out_valid SHALL rise 1 cycle after first mul_done in WAIT.
REQ-032 Pushes SHALL continue during ISSUE/WAIT/HOLD until full; no operation SHALL issue while HOLD.
REQ-033 out_prod SHALL be mul_p unmodified (no sign handling in this block).

Reset
REQ-034 rst SHALL override all activity, including mid-WAIT and mid-HOLD; in-flight result and FIFO contents discarded.
REQ-035 After reset: state IDLE, FIFO empty, in_ready=1, mul_start=0, mul_mc=0, mul_mp=0, out_valid=0, out_prod=0, out_tag=0, out_timeout=0, busy=0, counter 0.

Verification (bench uses behavioural multiplier: done 66 cycles after start, held high)
REQ-036 Push a=3,b=5,tag=1; out_ready=1 -> mul_start 1-cycle pulse with mc=3,mp=5; out_prod=15, tag=1, timeout=0.
REQ-037 Push a=b=0xFFFF_FFFF -> out_prod=0xFFFF_FFFE_0000_0001; push a=0,b=0x1234 -> out_prod=0.
REQ-038 Push 3 ops back-to-back, DEPTH=2, out_ready=0 -> in_ready drops after FIFO full; results return in order, one per out_ready, tags 1,2,3.
REQ-039 Model never asserts done -> out_valid after TIMEOUT WAIT cycles with out_prod=0, out_timeout=1; next op completes normally.
REQ-040 Stale done high from prior op during ISSUE -> no premature out_valid; result taken from fresh done.
REQ-041 rst asserted mid-WAIT with 1 entry queued -> next cycle outputs per REQ-035; no result ever emitted for discarded ops.
